posit_pack_8bit: RTL

POSIT_PACK_8BIT -- requirements
Module: posit_pack_8bit

---
 rtl/posit_pack_8bit_pkg.sv | 36 +++
 rtl/posit_round_rne8.sv | 30 +++
 rtl/posit_pack_8bit.sv | 99 +++++++++
 3 files changed

// File: rtl/posit_pack_8bit_pkg.sv
// Shared field positions, constants and stage-1 payload for the Posit8 (es=0) packer.
package posit_pack_8bit_pkg;

  localparam int UNP_W   = 21;
  localparam int POSIT_W = 8;
  localparam int BODY_W  = 7;
  localparam int EXP_W   = 5;
  localparam int FRAC_W  = 13;

  localparam int BIT_INF  = 20;
  localparam int BIT_ZERO = 19;
  localparam int BIT_SIGN = 18;
  localparam int EXP_MSB  = 17;
  localparam int EXP_LSB  = 13;
  localparam int FRAC_MSB = 12;
  localparam int FRAC_LSB = 0;

  localparam int EXP_BIAS = 15;

  localparam logic [POSIT_W-1:0] POSIT_NAR    = 8'h80;
  localparam logic [POSIT_W-1:0] POSIT_ZERO   = 8'h00;
  localparam logic [POSIT_W-1:0] POSIT_MAXPOS = 8'h7F;
  localparam logic [POSIT_W-1:0] POSIT_MINPOS = 8'h01;

  typedef struct packed {
    logic              inf;
    logic              zero;
    logic              sign;
    logic              sat_hi;
    logic              sat_lo;
    logic [BODY_W-1:0] body;
    logic              guard;
    logic              sticky;
  } s1_t;

endpackage

// File: rtl/posit_round_rne8.sv
// Round-to-nearest-even of the 7-bit posit body, then clamp the magnitude to minpos..maxpos.
module posit_round_rne8
  import posit_pack_8bit_pkg::*;
(
  input  logic [BODY_W-1:0]  i_body,
  input  logic               i_guard,
  input  logic               i_sticky,
  input  logic               i_sat_hi,
  input  logic               i_sat_lo,
  output logic [POSIT_W-1:0] o_mag
);

  function automatic logic [POSIT_W-1:0] rne_round(input logic [BODY_W-1:0] body,
                                                   input logic guard, input logic sticky);
    logic up;
    up = guard & (sticky | body[0]);
    return {1'b0, body} + {{(POSIT_W-1){1'b0}}, up};
  endfunction

  // A carry out of the regime lands on 0x80; that and any over-range exponent pin to maxpos.
  function automatic logic [POSIT_W-1:0] clamp_mag(input logic [POSIT_W-1:0] sum,
                                                   input logic sat_hi, input logic sat_lo);
    if (sat_hi || (sum > POSIT_MAXPOS)) return POSIT_MAXPOS;
    if (sat_lo || (sum == POSIT_ZERO))  return POSIT_MINPOS;
    return sum;
  endfunction

  assign o_mag = clamp_mag(rne_round(i_body, i_guard, i_sticky), i_sat_hi, i_sat_lo);

endmodule

// File: rtl/posit_pack_8bit.sv
// Two-stage packer: unpacked multiplier result -> Posit8 (es=0), valid/ready on both sides.
module posit_pack_8bit
  import posit_pack_8bit_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [UNP_W-1:0]   unpacked,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [POSIT_W-1:0] posit
);

  logic               r_vld_p1, r_vld_p2;
  s1_t                w_s1, r_s1_p1;
  logic [POSIT_W-1:0] r_posit_p2, w_posit, w_mag;
  logic               w_s2_en, w_s1_load;

  logic [EXP_W-1:0]   w_exp;
  logic [FRAC_W-1:0]  w_frac, w_mf;
  logic               w_sign, w_inc, w_k_neg;
  logic [6:0]         w_exp_adj;
  logic signed [6:0]  w_k;
  logic [2:0]         w_shamt;
  logic signed [31:0] w_seed;
  logic [31:0]        w_regime;

  assign w_s2_en   = !r_vld_p2 || out_ready;
  assign in_ready  = !r_vld_p1 || w_s2_en;
  assign w_s1_load = in_valid && in_ready;
  assign out_valid = r_vld_p2;
  assign posit     = r_posit_p2;

  // ---- stage 1: magnitude and regime ----
  assign w_sign = unpacked[BIT_SIGN];
  assign w_exp  = unpacked[EXP_MSB:EXP_LSB];
  assign w_frac = unpacked[FRAC_MSB:FRAC_LSB];

  // Negative values are -(2-f): fraction is the 13-bit two's complement, and f=0 bumps the exponent.
  assign w_inc     = w_sign && (w_frac == '0);
  assign w_mf      = w_sign ? (~w_frac + 13'd1) : w_frac;
  assign w_exp_adj = {2'b00, w_exp} + {6'b0, w_inc};
  assign w_k       = $signed(w_exp_adj - 7'(EXP_BIAS));
  assign w_k_neg   = w_k[6];

  // Seed "10" replicated by arithmetic shift gives k+1 ones; seed "01" logically shifted gives -k zeros.
  assign w_shamt  = w_k_neg ? ~w_k[2:0] : w_k[2:0];
  assign w_seed   = {(w_k_neg ? 2'b01 : 2'b10), w_mf, 17'b0};
  assign w_regime = w_k_neg ? (w_seed >> w_shamt) : (w_seed >>> w_shamt);

  always_comb begin
    w_s1        = '0;
    w_s1.inf    = unpacked[BIT_INF];
    w_s1.zero   = unpacked[BIT_ZERO];
    w_s1.sign   = w_sign;
    w_s1.sat_hi = (w_k > 7'sd5);
    w_s1.sat_lo = (w_k < -7'sd6);
    w_s1.body   = w_regime[31 -: BODY_W];
    w_s1.guard  = w_regime[31-BODY_W];
    w_s1.sticky = |w_regime[31-BODY_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (w_s1_load) r_s1_p1 <= w_s1;
  end

  // ---- stage 2: round, clamp, sign and specials ----
  posit_round_rne8 u_round (
    .i_body   (r_s1_p1.body),
    .i_guard  (r_s1_p1.guard),
    .i_sticky (r_s1_p1.sticky),
    .i_sat_hi (r_s1_p1.sat_hi),
    .i_sat_lo (r_s1_p1.sat_lo),
    .o_mag    (w_mag)
  );

  always_comb begin
    w_posit = w_mag;
    if (r_s1_p1.sign) w_posit = ~w_mag + 8'd1;
    if (r_s1_p1.zero) w_posit = POSIT_ZERO;
    if (r_s1_p1.inf)  w_posit = POSIT_NAR;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1   <= 1'b0;
      r_vld_p2   <= 1'b0;
      r_posit_p2 <= POSIT_ZERO;
    end else begin
      if (in_ready) r_vld_p1 <= in_valid;
      if (w_s2_en) begin
        r_vld_p2 <= r_vld_p1;
        if (r_vld_p1) r_posit_p2 <= w_posit;
      end
    end
  end

endmodule
